// File: rtl/knn_result_display_if.sv
// Bus between the KNN classifier side and the result display.
//   master: drives classifier state/label/unknown plus user controls (mode, clr_counts),
//           observes the capture strobe, result flag and seven-segment lines.
//   slave : the display block; the mirror image of master.
// Signals:
//   state[1:0]      classifier state
//   label[1:0]      classifier label, stable while state is the DONE encoding
//   unknown[6:0]    sample being classified
//   mode            0 = result view, 1 = count view
//   clr_counts      clear all per-label counters
//   done_pulse      one-cycle strobe on each new capture
//   result_valid    at least one result has been captured
//   an[3:0]         digit enables, active-low, an[0] rightmost
//   seg[6:0]        {g,f,e,d,c,b,a}, active-low
interface knn_result_display_if;
    logic [1:0] state;
    logic [1:0] label;
    logic [6:0] unknown;
    logic       mode;
    logic       clr_counts;
    logic       done_pulse;
    logic       result_valid;
    logic [3:0] an;
    logic [6:0] seg;

    modport master (
        output state, label, unknown, mode, clr_counts,
        input  done_pulse, result_valid, an, seg
    );

    modport slave (
        input  state, label, unknown, mode, clr_counts,
        output done_pulse, result_valid, an, seg
    );
endinterface

// File: rtl/knn_result_display.sv
// Result display for the KNN classifier.
// Detects entry into the classifier's DONE state, captures label and unknown sample,
// keeps saturating per-label counts, and scans a 4-digit active-low seven-segment display.
// Ports:
//   clk  - board clock (100 MHz)
//   rst  - synchronous, active-high reset
//   bus  - knn_result_display_if.slave: state/label/unknown/mode/clr_counts in,
//          done_pulse/result_valid/an/seg out
// Parameters:
//   REFRESH_DIV - clk cycles per digit slot, >= 2
//   DONE_STATE  - state encoding meaning "result valid"
//   CNT_W       - per-label counter width, <= 8 (shown as two hex digits)
module knn_result_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter logic [1:0]  DONE_STATE  = 2'b11,
    parameter int unsigned CNT_W       = 8
) (
    input logic                 clk,
    input logic                 rst,
    knn_result_display_if.slave bus
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

    // Display symbols: 0..15 are hex digits, plus two non-numeric glyphs.
    localparam logic [4:0] SYM_DASH  = 5'd16;
    localparam logic [4:0] SYM_BLANK = 5'd17;

    // Input staging
    logic [1:0] s1_q, s2_q;
    logic [1:0] l1_q;
    logic [6:0] u1_q;

    // Captured result and counts
    logic [1:0]       cap_label_q;
    logic [7:0]       cap_unk_q;
    logic             result_valid_q;
    logic             done_pulse_q;
    logic [CNT_W-1:0] count_q [4];

    // Scan
    logic [RW-1:0] refresh_q;
    logic [1:0]    idx_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;

    logic       capture;
    logic [7:0] cnt_ext;
    logic [4:0] digit_sym [4];
    logic [4:0] sym;

    // Rising edge of "state is DONE" on the staged copy, so a held DONE captures once.
    assign capture = (s1_q == DONE_STATE) && (s2_q != DONE_STATE);

    function automatic logic [6:0] seg_code(input logic [4:0] s);
        logic [6:0] c;
        case (s)
            5'd0:    c = 7'b1000000;
            5'd1:    c = 7'b1111001;
            5'd2:    c = 7'b0100100;
            5'd3:    c = 7'b0110000;
            5'd4:    c = 7'b0011001;
            5'd5:    c = 7'b0010010;
            5'd6:    c = 7'b0000010;
            5'd7:    c = 7'b1111000;
            5'd8:    c = 7'b0000000;
            5'd9:    c = 7'b0010000;
            5'd10:   c = 7'b0001000;
            5'd11:   c = 7'b0000011;
            5'd12:   c = 7'b1000110;
            5'd13:   c = 7'b0100001;
            5'd14:   c = 7'b0000110;
            5'd15:   c = 7'b0001110;
            SYM_DASH: c = 7'b0111111;
            default: c = 7'b1111111;
        endcase
        return c;
    endfunction

    // Staging, capture and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q           <= '0;
            s2_q           <= '0;
            l1_q           <= '0;
            u1_q           <= '0;
            cap_label_q    <= '0;
            cap_unk_q      <= '0;
            result_valid_q <= 1'b0;
            done_pulse_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            s1_q         <= bus.state;
            s2_q         <= s1_q;
            l1_q         <= bus.label;
            u1_q         <= bus.unknown;
            done_pulse_q <= capture;

            if (bus.clr_counts) begin
                for (int i = 0; i < 4; i++) begin
                    count_q[i] <= '0;
                end
            end

            if (capture) begin
                cap_label_q    <= l1_q;
                cap_unk_q      <= {1'b0, u1_q};
                result_valid_q <= 1'b1;
                // A clear in the same cycle still counts this capture as the first.
                if (bus.clr_counts) begin
                    count_q[l1_q] <= CNT_W'(1);
                end else if (count_q[l1_q] != '1) begin
                    count_q[l1_q] <= count_q[l1_q] + CNT_W'(1);
                end
            end
        end
    end

    // Digit contents, d3 leftmost (index 3)
    always_comb begin
        cnt_ext                = '0;
        cnt_ext[CNT_W-1:0]     = count_q[cap_label_q];
        digit_sym[0]           = SYM_DASH;
        digit_sym[1]           = SYM_DASH;
        digit_sym[2]           = SYM_DASH;
        digit_sym[3]           = SYM_DASH;
        if (result_valid_q) begin
            digit_sym[3] = {3'b000, cap_label_q};
            if (!bus.mode) begin
                digit_sym[2] = SYM_DASH;
                digit_sym[1] = {1'b0, cap_unk_q[7:4]};
                digit_sym[0] = {1'b0, cap_unk_q[3:0]};
            end else begin
                digit_sym[2] = SYM_BLANK;
                digit_sym[1] = {1'b0, cnt_ext[7:4]};
                digit_sym[0] = {1'b0, cnt_ext[3:0]};
            end
        end
    end

    assign sym = digit_sym[idx_q];

    // Scan: an/seg are registered from the current index, so they lag it by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            idx_q     <= '0;
            an_q      <= 4'b1111;
            seg_q     <= 7'b1111111;
        end else begin
            if (refresh_q == REFRESH_MAX) begin
                refresh_q <= '0;
                idx_q     <= idx_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + RW'(1);
            end
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= seg_code(sym);
        end
    end

    assign bus.done_pulse   = done_pulse_q;
    assign bus.result_valid = result_valid_q;
    assign bus.an           = an_q;
    assign bus.seg          = seg_q;

endmodule
